audio_frame_fifo: RTL and testbench

Byte-write, frame-read PCM FIFO for the audio path. The CPU/bus side pushes raw PCM bytes. The audio-playback side requests whole sample frames, which the block assembles according to the current sample format: 8/16-bit, mono/stereo. It adds parametrised depth, a fill level, a programmable low-water threshold, flush, silence-on-underrun, and sticky overflow/underrun flags.

---
 rtl/audio_frame_fifo_if.sv | 34 +++
 rtl/audio_frame_fifo.sv | 173 +++++++++++++++++
 tb/tb_audio_frame_fifo.sv | 299 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/audio_frame_fifo_if.sv
// Bus bundle for the audio frame FIFO: CPU byte pushes, playback frame requests and status.
// master drives pushes/requests/configuration; slave is the FIFO itself.
interface audio_frame_fifo_if #(
    parameter int ADDR_WIDTH = 12
) ();
    logic [7:0]            wrdata;
    logic                  wr_en;
    logic                  flush;
    logic                  mode_16bit;
    logic                  mode_stereo;
    logic [ADDR_WIDTH:0]   threshold;
    logic                  frame_req;
    logic                  flag_clr;
    logic [15:0]           left;
    logic [15:0]           right;
    logic                  frame_valid;
    logic                  busy;
    logic [ADDR_WIDTH:0]   level;
    logic                  empty;
    logic                  full;
    logic                  almost_empty;
    logic                  overflow;
    logic                  underrun;

    modport master (
        output wrdata, wr_en, flush, mode_16bit, mode_stereo, threshold, frame_req, flag_clr,
        input  left, right, frame_valid, busy, level, empty, full, almost_empty, overflow, underrun
    );

    modport slave (
        input  wrdata, wr_en, flush, mode_16bit, mode_stereo, threshold, frame_req, flag_clr,
        output left, right, frame_valid, busy, level, empty, full, almost_empty, overflow, underrun
    );
endinterface

// File: rtl/audio_frame_fifo.sv
// Byte-write, frame-read PCM FIFO: bytes pushed by the CPU are assembled into
// 8/16-bit mono/stereo frames on request, with silence on underrun.
//
// state | meaning
// IDLE  | waiting for frame_req; decides fetch or silence
// FETCH | one byte read per cycle until the frame is complete
// DONE  | frame_valid pulse, left/right just updated
module audio_frame_fifo #(
    parameter int ADDR_WIDTH = 12
) (
    input  logic                clk,
    input  logic                rst,
    audio_frame_fifo_if.slave   bus
);
    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam int LW    = ADDR_WIDTH + 1;

    typedef enum logic [1:0] {IDLE, FETCH, DONE} state_t;

    state_t              r_state;
    logic [7:0]          r_mem [DEPTH];
    logic [LW-1:0]       r_wridx;
    logic [LW-1:0]       r_rdidx;
    logic                r_m16;
    logic                r_mst;
    logic [1:0]          r_cnt;
    logic [7:0]          r_byte [4];
    logic [15:0]         r_left;
    logic [15:0]         r_right;
    logic                r_valid;
    logic                r_ovf;
    logic                r_unf;

    logic [LW-1:0]       w_level;
    logic                w_full;
    logic                w_wr_ok;
    logic [2:0]          w_n_req;
    logic [2:0]          w_n_lat;
    logic                w_level_ok;
    logic                w_last;
    logic [7:0]          w_rd_byte;
    logic [7:0]          w_fb [4];
    logic [15:0]         w_asm_left;
    logic [15:0]         w_asm_right;
    logic                w_ovf_set;
    logic                w_unf_set;

    function automatic logic [2:0] frame_bytes(input logic m16, input logic mst);
        case ({m16, mst})
            2'b00:   return 3'd1;
            2'b11:   return 3'd4;
            default: return 3'd2;
        endcase
    endfunction

    assign w_level    = r_wridx - r_rdidx;
    assign w_full     = (w_level == {1'b1, {ADDR_WIDTH{1'b0}}});
    assign w_wr_ok    = bus.wr_en && !w_full && !bus.flush && !rst;
    assign w_n_req    = frame_bytes(bus.mode_16bit, bus.mode_stereo);
    assign w_n_lat    = frame_bytes(r_m16, r_mst);
    assign w_level_ok = (w_level >= LW'(w_n_req));
    assign w_last     = ({1'b0, r_cnt} == (w_n_lat - 3'd1));
    assign w_rd_byte  = r_mem[r_rdidx[ADDR_WIDTH-1:0]];
    assign w_ovf_set  = bus.wr_en && w_full && !bus.flush;
    assign w_unf_set  = (r_state == IDLE) && bus.frame_req && !w_level_ok && !bus.flush;

    // The byte being read this cycle joins the frame directly so the last read
    // lands in left/right on the same edge that raises frame_valid.
    always_comb begin
        for (int k = 0; k < 4; k++) begin
            w_fb[k] = (r_cnt == 2'(k)) ? w_rd_byte : r_byte[k];
        end
        w_asm_left  = {w_fb[0], 8'h00};
        w_asm_right = {w_fb[0], 8'h00};
        case ({r_m16, r_mst})
            2'b01: w_asm_right = {w_fb[1], 8'h00};
            2'b10: begin
                w_asm_left  = {w_fb[1], w_fb[0]};
                w_asm_right = {w_fb[1], w_fb[0]};
            end
            2'b11: begin
                w_asm_left  = {w_fb[1], w_fb[0]};
                w_asm_right = {w_fb[3], w_fb[2]};
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (w_wr_ok) begin
            r_mem[r_wridx[ADDR_WIDTH-1:0]] <= bus.wrdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ovf <= 1'b0;
            r_unf <= 1'b0;
        end else begin
            if (bus.flag_clr) begin
                r_ovf <= 1'b0;
                r_unf <= 1'b0;
            end
            if (w_ovf_set) r_ovf <= 1'b1;
            if (w_unf_set) r_unf <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_wridx <= '0;
            r_rdidx <= '0;
            r_m16   <= 1'b0;
            r_mst   <= 1'b0;
            r_cnt   <= 2'd0;
            r_left  <= 16'h0000;
            r_right <= 16'h0000;
            r_valid <= 1'b0;
            for (int k = 0; k < 4; k++) r_byte[k] <= 8'h00;
        end else if (bus.flush) begin
            r_state <= IDLE;
            r_wridx <= '0;
            r_rdidx <= '0;
            r_cnt   <= 2'd0;
            r_valid <= 1'b0;
        end else begin
            if (w_wr_ok) r_wridx <= r_wridx + LW'(1);
            r_valid <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (bus.frame_req) begin
                        if (w_level_ok) begin
                            r_m16   <= bus.mode_16bit;
                            r_mst   <= bus.mode_stereo;
                            r_cnt   <= 2'd0;
                            r_state <= FETCH;
                        end else begin
                            r_left  <= 16'h0000;
                            r_right <= 16'h0000;
                            r_valid <= 1'b1;
                            r_state <= DONE;
                        end
                    end
                end
                FETCH: begin
                    r_byte[r_cnt] <= w_rd_byte;
                    r_rdidx       <= r_rdidx + LW'(1);
                    r_cnt         <= r_cnt + 2'd1;
                    if (w_last) begin
                        r_left  <= w_asm_left;
                        r_right <= w_asm_right;
                        r_valid <= 1'b1;
                        r_state <= DONE;
                    end
                end
                DONE:    r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.left         = r_left;
    assign bus.right        = r_right;
    assign bus.frame_valid  = r_valid;
    assign bus.busy         = (r_state != IDLE);
    assign bus.level        = w_level;
    assign bus.empty        = (w_level == '0);
    assign bus.full         = w_full;
    assign bus.almost_empty = (w_level < bus.threshold);
    assign bus.overflow     = r_ovf;
    assign bus.underrun     = r_unf;
endmodule

// File: tb/tb_audio_frame_fifo.sv
// Directed bench for audio_frame_fifo (ADDR_WIDTH = 4): a vector table for the
// single-frame paths plus hand sequences for wrap, overflow, flush and reset.
module tb_audio_frame_fifo;
    localparam int AW = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    audio_frame_fifo_if #(.ADDR_WIDTH(AW)) bus ();
    audio_frame_fifo #(.ADDR_WIDTH(AW)) dut (.clk(clk), .rst(rst), .bus(bus));

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic        wr;
        logic [7:0]  d;
        logic        req;
        logic        clr;
        logic        m16;
        logic        mst;
        logic        e_valid;
        logic        e_busy;
        logic [4:0]  e_level;
        logic [15:0] e_left;
        logic [15:0] e_right;
        logic        e_ur;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        bus.wr_en     = 1'b0;
        bus.frame_req = 1'b0;
        bus.flush     = 1'b0;
        bus.flag_clr  = 1'b0;
    endtask

    task automatic wr(input logic [7:0] d);
        bus.wr_en  = 1'b1;
        bus.wrdata = d;
        step();
        bus.wr_en  = 1'b0;
    endtask

    task automatic add(input logic wr_i, input logic [7:0] d, input logic req, input logic clr,
                       input logic m16, input logic mst, input logic ev, input logic eb,
                       input logic [4:0] lvl, input logic [15:0] l, input logic [15:0] r,
                       input logic ur);
        vec_t v;
        v.wr = wr_i; v.d = d; v.req = req; v.clr = clr; v.m16 = m16; v.mst = mst;
        v.e_valid = ev; v.e_busy = eb; v.e_level = lvl; v.e_left = l; v.e_right = r; v.e_ur = ur;
        tbl.push_back(v);
    endtask

    // Request one frame and wait (bounded) for it; lat = 0 means it never came.
    task automatic get_frame(input logic m16, input logic mst,
                             output logic [15:0] l, output logic [15:0] r, output int lat);
        bus.mode_16bit  = m16;
        bus.mode_stereo = mst;
        bus.frame_req   = 1'b1;
        lat = 0; l = '0; r = '0;
        for (int k = 1; k <= 12; k++) begin
            step();
            bus.frame_req = 1'b0;
            if (bus.frame_valid) begin
                lat = k; l = bus.left; r = bus.right;
                break;
            end
        end
        step();
    endtask

    function automatic logic [7:0] pat(input int k);
        return 8'((k * 37 + 5) & 255);
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not reach its summary");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [15:0] fl, fr, pl, pr;
        int          lat, w, got, seen;

        rst = 1'b1;
        idle_in();
        bus.wrdata      = 8'h00;
        bus.mode_16bit  = 1'b0;
        bus.mode_stereo = 1'b0;
        bus.threshold   = '0;
        step();
        step();
        rst = 1'b0;

        // reset values
        chk("rst.valid", 32'(bus.frame_valid), 32'd0);
        chk("rst.busy", 32'(bus.busy), 32'd0);
        chk("rst.level", 32'(bus.level), 32'd0);
        chk("rst.empty", 32'(bus.empty), 32'd1);
        chk("rst.full", 32'(bus.full), 32'd0);
        chk("rst.ae_thr0", 32'(bus.almost_empty), 32'd0);
        chk("rst.ovf", 32'(bus.overflow), 32'd0);
        chk("rst.ur", 32'(bus.underrun), 32'd0);
        chk("rst.left", 32'(bus.left), 32'd0);
        bus.threshold = 5'd3;
        #1;
        chk("rst.ae_thr3", 32'(bus.almost_empty), 32'd1);

        // wr d req clr m16 mst | valid busy level left right underrun (next cycle)
        add(1, 8'h34, 0, 0, 1, 1, 0, 0, 1, 16'h0000, 16'h0000, 0);
        add(1, 8'h12, 0, 0, 1, 1, 0, 0, 2, 16'h0000, 16'h0000, 0);
        add(1, 8'h78, 0, 0, 1, 1, 0, 0, 3, 16'h0000, 16'h0000, 0);
        add(1, 8'h56, 0, 0, 1, 1, 0, 0, 4, 16'h0000, 16'h0000, 0);
        add(0, 8'h00, 1, 0, 1, 1, 0, 1, 4, 16'h0000, 16'h0000, 0);
        add(0, 8'h00, 0, 0, 1, 1, 0, 1, 3, 16'h0000, 16'h0000, 0);
        add(0, 8'h00, 0, 0, 1, 1, 0, 1, 2, 16'h0000, 16'h0000, 0);
        add(0, 8'h00, 0, 0, 1, 1, 0, 1, 1, 16'h0000, 16'h0000, 0);
        add(0, 8'h00, 0, 0, 1, 1, 1, 1, 0, 16'h1234, 16'h5678, 0);
        add(0, 8'h00, 0, 0, 1, 1, 0, 0, 0, 16'h1234, 16'h5678, 0);
        add(1, 8'h80, 0, 0, 0, 0, 0, 0, 1, 16'h1234, 16'h5678, 0);
        add(0, 8'h00, 1, 0, 0, 0, 0, 1, 1, 16'h1234, 16'h5678, 0);
        add(0, 8'h00, 0, 0, 0, 0, 1, 1, 0, 16'h8000, 16'h8000, 0);
        add(0, 8'h00, 0, 0, 0, 0, 0, 0, 0, 16'h8000, 16'h8000, 0);
        add(1, 8'h01, 0, 0, 1, 1, 0, 0, 1, 16'h8000, 16'h8000, 0);
        add(1, 8'h02, 0, 0, 1, 1, 0, 0, 2, 16'h8000, 16'h8000, 0);
        add(1, 8'h03, 0, 0, 1, 1, 0, 0, 3, 16'h8000, 16'h8000, 0);
        add(0, 8'h00, 1, 0, 1, 1, 1, 1, 3, 16'h0000, 16'h0000, 1);
        add(0, 8'h00, 0, 0, 1, 1, 0, 0, 3, 16'h0000, 16'h0000, 1);
        add(0, 8'h00, 0, 1, 1, 1, 0, 0, 3, 16'h0000, 16'h0000, 0);
        add(0, 8'h00, 1, 0, 0, 1, 0, 1, 3, 16'h0000, 16'h0000, 0);
        add(0, 8'h00, 0, 0, 0, 1, 0, 1, 2, 16'h0000, 16'h0000, 0);
        add(0, 8'h00, 0, 0, 0, 1, 1, 1, 1, 16'h0100, 16'h0200, 0);
        add(0, 8'h00, 0, 0, 0, 1, 0, 0, 1, 16'h0100, 16'h0200, 0);
        add(1, 8'h7f, 0, 0, 0, 1, 0, 0, 2, 16'h0100, 16'h0200, 0);
        add(0, 8'h00, 1, 0, 1, 0, 0, 1, 2, 16'h0100, 16'h0200, 0);
        add(0, 8'h00, 0, 0, 0, 1, 0, 1, 1, 16'h0100, 16'h0200, 0);
        add(0, 8'h00, 0, 0, 0, 1, 1, 1, 0, 16'h7f03, 16'h7f03, 0);
        add(0, 8'h00, 0, 0, 0, 1, 0, 0, 0, 16'h7f03, 16'h7f03, 0);
        add(0, 8'h00, 1, 1, 0, 0, 1, 1, 0, 16'h0000, 16'h0000, 1);
        add(0, 8'h00, 0, 0, 0, 0, 0, 0, 0, 16'h0000, 16'h0000, 1);
        add(0, 8'h00, 0, 1, 0, 0, 0, 0, 0, 16'h0000, 16'h0000, 0);

        bus.threshold = 5'd2;
        foreach (tbl[i]) begin
            bus.wr_en       = tbl[i].wr;
            bus.wrdata      = tbl[i].d;
            bus.frame_req   = tbl[i].req;
            bus.flag_clr    = tbl[i].clr;
            bus.mode_16bit  = tbl[i].m16;
            bus.mode_stereo = tbl[i].mst;
            step();
            idle_in();
            chk($sformatf("v%0d.valid", i), 32'(bus.frame_valid), 32'(tbl[i].e_valid));
            chk($sformatf("v%0d.busy", i), 32'(bus.busy), 32'(tbl[i].e_busy));
            chk($sformatf("v%0d.level", i), 32'(bus.level), 32'(tbl[i].e_level));
            chk($sformatf("v%0d.left", i), 32'(bus.left), 32'(tbl[i].e_left));
            chk($sformatf("v%0d.right", i), 32'(bus.right), 32'(tbl[i].e_right));
            chk($sformatf("v%0d.underrun", i), 32'(bus.underrun), 32'(tbl[i].e_ur));
            chk($sformatf("v%0d.overflow", i), 32'(bus.overflow), 32'd0);
            chk($sformatf("v%0d.empty", i), 32'(bus.empty), 32'(tbl[i].e_level == 5'd0));
            chk($sformatf("v%0d.ae", i), 32'(bus.almost_empty), 32'(tbl[i].e_level < 5'd2));
        end

        // low-water threshold crossing
        bus.threshold = 5'd4;
        wr(8'hc1); wr(8'hc2); wr(8'hc3);
        chk("thr.ae_at3", 32'(bus.almost_empty), 32'd1);
        wr(8'hc4);
        chk("thr.ae_at4", 32'(bus.almost_empty), 32'd0);
        chk("thr.level", 32'(bus.level), 32'd4);

        // full and overflow
        bus.flush = 1'b1; step(); bus.flush = 1'b0;
        chk("flush.level", 32'(bus.level), 32'd0);
        for (int i = 0; i < 16; i++) wr(8'ha0 + 8'(i));
        chk("full.full", 32'(bus.full), 32'd1);
        chk("full.level", 32'(bus.level), 32'd16);
        chk("full.ovf0", 32'(bus.overflow), 32'd0);
        wr(8'hee);
        chk("ovf.ovf", 32'(bus.overflow), 32'd1);
        chk("ovf.level", 32'(bus.level), 32'd16);
        for (int f = 0; f < 4; f++) begin
            get_frame(1'b1, 1'b1, fl, fr, lat);
            chk($sformatf("full.f%0d.lat", f), 32'(lat), 32'd5);
            chk($sformatf("full.f%0d.left", f), 32'(fl), 32'({8'ha1 + 8'(4*f), 8'ha0 + 8'(4*f)}));
            chk($sformatf("full.f%0d.right", f), 32'(fr), 32'({8'ha3 + 8'(4*f), 8'ha2 + 8'(4*f)}));
        end
        bus.flag_clr = 1'b1; step(); bus.flag_clr = 1'b0;
        chk("ovf.clr", 32'(bus.overflow), 32'd0);

        // 100 frames through the pointer wrap, writing ahead while fetching
        bus.flush = 1'b1; step(); bus.flush = 1'b0;
        for (int i = 0; i < 4; i++) wr(pat(i));
        w = 4;
        bus.mode_16bit  = 1'b1;
        bus.mode_stereo = 1'b1;
        for (int f = 0; f < 100; f++) begin
            bus.frame_req = 1'b1;
            got = 0;
            for (int k = 1; k <= 12; k++) begin
                if (w < 4 * (f + 2) && w < 400) begin
                    bus.wr_en = 1'b1; bus.wrdata = pat(w); w++;
                end else begin
                    bus.wr_en = 1'b0;
                end
                step();
                bus.frame_req = 1'b0;
                if (bus.frame_valid) begin
                    got = k;
                    break;
                end
            end
            bus.wr_en = 1'b0;
            chk($sformatf("wrap.f%0d.lat", f), 32'(got), 32'd5);
            chk($sformatf("wrap.f%0d.left", f), 32'(bus.left), 32'({pat(4*f+1), pat(4*f)}));
            chk($sformatf("wrap.f%0d.right", f), 32'(bus.right), 32'({pat(4*f+3), pat(4*f+2)}));
            step();
        end
        chk("wrap.level", 32'(bus.level), 32'd0);
        chk("wrap.ovf", 32'(bus.overflow), 32'd0);
        pl = {pat(397), pat(396)};
        pr = {pat(399), pat(398)};

        // flush in the middle of a fetch
        wr(8'h11); wr(8'h22); wr(8'h33); wr(8'h44);
        bus.frame_req = 1'b1; step(); bus.frame_req = 1'b0;
        step();
        bus.flush = 1'b1; step(); bus.flush = 1'b0;
        chk("mflush.busy", 32'(bus.busy), 32'd0);
        chk("mflush.level", 32'(bus.level), 32'd0);
        chk("mflush.valid", 32'(bus.frame_valid), 32'd0);
        chk("mflush.left", 32'(bus.left), 32'(pl));
        chk("mflush.right", 32'(bus.right), 32'(pr));
        seen = 0;
        for (int k = 0; k < 4; k++) begin
            step();
            if (bus.frame_valid) seen++;
        end
        chk("mflush.novalid", 32'(seen), 32'd0);

        // reset in the middle of a fetch, with underrun already set
        get_frame(1'b0, 1'b0, fl, fr, lat);
        chk("mrst.ur_set", 32'(bus.underrun), 32'd1);
        wr(8'h55); wr(8'h66); wr(8'h77); wr(8'h88);
        bus.frame_req = 1'b1; step(); bus.frame_req = 1'b0;
        step();
        rst = 1'b1; step(); rst = 1'b0;
        chk("mrst.valid", 32'(bus.frame_valid), 32'd0);
        chk("mrst.busy", 32'(bus.busy), 32'd0);
        chk("mrst.level", 32'(bus.level), 32'd0);
        chk("mrst.empty", 32'(bus.empty), 32'd1);
        chk("mrst.ae", 32'(bus.almost_empty), 32'd1);
        chk("mrst.ur", 32'(bus.underrun), 32'd0);
        chk("mrst.left", 32'(bus.left), 32'd0);
        chk("mrst.right", 32'(bus.right), 32'd0);
        seen = 0;
        for (int k = 0; k < 4; k++) begin
            step();
            if (bus.frame_valid) seen++;
        end
        chk("mrst.novalid", 32'(seen), 32'd0);

        // frame_req held through the busy window yields exactly one frame
        for (int i = 1; i <= 8; i++) wr(8'(i));
        bus.mode_16bit  = 1'b1;
        bus.mode_stereo = 1'b1;
        bus.frame_req   = 1'b1;
        seen = 0;
        for (int k = 1; k <= 12; k++) begin
            step();
            if (k == 6) bus.frame_req = 1'b0;
            if (bus.frame_valid) seen++;
        end
        chk("hold.frames", 32'(seen), 32'd1);
        chk("hold.level", 32'(bus.level), 32'd4);
        chk("hold.left", 32'(bus.left), 32'h0201);
        chk("hold.right", 32'(bus.right), 32'h0403);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
